// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the 8502-side bus cycle arbiter.
// MAX_WRITES_DFLT is also used by the bridge testbench.
package bus_arb_pkg;
  localparam int MAX_WRITES_DFLT = 3;
  localparam int WCNT_W          = 2;

  typedef enum logic [2:0] {
    ST_CPU   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_VIC   = 3'd2,
    ST_DMA   = 3'd3,
    ST_YIELD = 3'd4
  } arb_state_t;
endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// Request/grant bundle between the bus masters and the cycle arbiter.
interface bus_cycle_arbiter_if;
  import bus_arb_pkg::*;

  logic              r_w_6502;
  logic              ba_req;
  logic              dma_req;
  logic              aec;
  logic              rdy;
  logic              vic_grant;
  logic              dma_grant;
  logic [WCNT_W-1:0] wait_cnt;

  modport master (
    output r_w_6502, ba_req, dma_req,
    input  aec, rdy, vic_grant, dma_grant, wait_cnt
  );

  modport slave (
    input  r_w_6502, ba_req, dma_req,
    output aec, rdy, vic_grant, dma_grant, wait_cnt
  );
endinterface

// File: rtl/arb_write_drain.sv
// Counts back-to-back core writes while rdy is low; drain_done marks the
// point where the core can no longer hold the bus.
module arb_write_drain
  import bus_arb_pkg::*;
#(
  parameter int MAX_WRITES = MAX_WRITES_DFLT
) (
  input  logic              clock,
  input  logic              _reset,
  input  logic              i_inc,
  output logic [WCNT_W-1:0] o_wait_cnt,
  output logic              o_drain_done
);
  logic [WCNT_W-1:0] r_cnt;

  // Any cycle that does not extend the drain restarts the count.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset)    r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + WCNT_W'(1);
    else            r_cnt <= '0;
  end

  assign o_wait_cnt   = r_cnt;
  assign o_drain_done = (r_cnt == WCNT_W'(MAX_WRITES));
endmodule

// File: rtl/bus_cycle_arbiter.sv
// Per-cycle owner of the 8502 bus: core (via bridge aec), video BA, or DMA.
// Outputs decode straight from the state register, so reset clears grants at once.
module bus_cycle_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_WRITES = MAX_WRITES_DFLT,
  parameter int MAX_BURST  = 0,
  parameter int BURST_W    = 8
) (
  input  logic                 clock,
  input  logic                 _reset,
  bus_cycle_arbiter_if.slave   bus
);
  arb_state_t         r_state, w_next;
  logic [BURST_W-1:0] r_burst;
  logic               w_any, w_drain_inc, w_drain_done, w_burst_end;

  assign w_any = bus.ba_req | bus.dma_req;

  arb_write_drain #(.MAX_WRITES(MAX_WRITES)) u_drain (
    .clock        (clock),
    ._reset       (_reset),
    .i_inc        (w_drain_inc),
    .o_wait_cnt   (bus.wait_cnt),
    .o_drain_done (w_drain_done)
  );

  // Burst length counts DMA cycles in the current run; cleared in any other state.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset)                  r_burst <= '0;
    else if (r_state == ST_DMA) begin
      if (r_burst != '1)          r_burst <= r_burst + BURST_W'(1);
    end else                      r_burst <= '0;
  end

  generate
    if (MAX_BURST == 0) begin : g_unlimited
      assign w_burst_end = 1'b0;
    end else begin : g_limited
      assign w_burst_end = (r_burst == BURST_W'(MAX_BURST - 1));
    end
  endgenerate

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) r_state <= ST_CPU;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_drain_inc = 1'b0;
    case (r_state)
      ST_CPU:   if (w_any) w_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_any)                             w_next = ST_CPU;
        else if (bus.r_w_6502 || w_drain_done)  w_next = bus.ba_req ? ST_VIC : ST_DMA;
        else                                    w_drain_inc = 1'b1;
      end
      // Core is already halted here, so DMA can follow without another drain.
      ST_VIC:   if (!bus.ba_req) w_next = bus.dma_req ? ST_DMA : ST_CPU;
      ST_DMA: begin
        if (bus.ba_req)       w_next = ST_VIC;
        else if (!bus.dma_req) w_next = ST_CPU;
        else if (w_burst_end) w_next = ST_YIELD;
      end
      ST_YIELD: w_next = w_any ? ST_DRAIN : ST_CPU;
      default:  w_next = ST_CPU;
    endcase
  end

  assign bus.aec       = (r_state == ST_CPU) || (r_state == ST_DRAIN) || (r_state == ST_YIELD);
  assign bus.rdy       = (r_state == ST_CPU) || (r_state == ST_YIELD);
  assign bus.vic_grant = (r_state == ST_VIC);
  assign bus.dma_grant = (r_state == ST_DMA);
endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Scoreboard bench for bus_cycle_arbiter: a spec-level model queues the expected
// outputs for each driven cycle, and they are popped after the following edge.
module tb_bus_cycle_arbiter;
  import bus_arb_pkg::*;

  localparam int MW = MAX_WRITES_DFLT;
  localparam int MB = 4;
  localparam int S_CPU = 0, S_DRAIN = 1, S_VIC = 2, S_DMA = 3, S_YIELD = 4;

  logic clock = 1'b0;
  logic _reset;
  always #5 clock = ~clock;

  bus_cycle_arbiter_if bus_if();

  bus_cycle_arbiter #(.MAX_WRITES(MW), .MAX_BURST(MB), .BURST_W(8)) dut (
    .clock  (clock),
    ._reset (_reset),
    .bus    (bus_if)
  );

  typedef struct packed {
    logic       aec;
    logic       rdy;
    logic       vic;
    logic       dma;
    logic [1:0] wc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_st, m_wc, m_bc;
  int   dma_run;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mexp(input int st, input int wc);
    exp_t e;
    e.aec = (st == S_CPU) || (st == S_DRAIN) || (st == S_YIELD);
    e.rdy = (st == S_CPU) || (st == S_YIELD);
    e.vic = (st == S_VIC);
    e.dma = (st == S_DMA);
    e.wc  = 2'(wc);
    return e;
  endfunction

  task mreset();
    m_st = S_CPU; m_wc = 0; m_bc = 0; dma_run = 0;
  endtask

  task mstep(input logic rw, input logic ba, input logic dma);
    case (m_st)
      S_CPU:   if (ba || dma) begin m_st = S_DRAIN; m_wc = 0; end
      S_DRAIN: begin
        if (!ba && !dma) begin m_st = S_CPU; m_wc = 0; end
        else if (rw || m_wc == MW) begin m_st = ba ? S_VIC : S_DMA; m_wc = 0; m_bc = 0; end
        else m_wc++;
      end
      S_VIC:   if (!ba) begin m_st = dma ? S_DMA : S_CPU; m_bc = 0; end
      S_DMA: begin
        if (ba)                m_st = S_VIC;
        else if (!dma)         m_st = S_CPU;
        else if (m_bc == MB-1) m_st = S_YIELD;
        else                   m_bc++;
      end
      default: begin m_bc = 0; m_wc = 0; m_st = (ba || dma) ? S_DRAIN : S_CPU; end
    endcase
  endtask

  // Called at posedge+1: drive, predict, advance one edge, compare.
  task cyc(input logic rw, input logic ba, input logic dma);
    exp_t e;
    bus_if.r_w_6502 = rw;
    bus_if.ba_req   = ba;
    bus_if.dma_req  = dma;
    mstep(rw, ba, dma);
    q.push_back(mexp(m_st, m_wc));
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("aec",       8'(bus_if.aec),       8'(e.aec));
    chk("rdy",       8'(bus_if.rdy),       8'(e.rdy));
    chk("vic_grant", 8'(bus_if.vic_grant), 8'(e.vic));
    chk("dma_grant", 8'(bus_if.dma_grant), 8'(e.dma));
    chk("wait_cnt",  8'(bus_if.wait_cnt),  8'(e.wc));
    chk("one_owner", 8'(bus_if.aec) + 8'(bus_if.vic_grant) + 8'(bus_if.dma_grant), 8'd1);
    if (bus_if.dma_grant) dma_run++;
    else begin
      if (m_st == S_YIELD) chk("burst_len", 8'(dma_run), 8'(MB));
      dma_run = 0;
    end
  endtask

  task chk_idle(input string tag);
    chk({tag, "_aec"}, 8'(bus_if.aec),       8'd1);
    chk({tag, "_rdy"}, 8'(bus_if.rdy),       8'd1);
    chk({tag, "_vic"}, 8'(bus_if.vic_grant), 8'd0);
    chk({tag, "_dma"}, 8'(bus_if.dma_grant), 8'd0);
    chk({tag, "_wc"},  8'(bus_if.wait_cnt),  8'd0);
  endtask

  logic ba_r, dma_r;

  initial begin
    _reset = 1'b0;
    bus_if.r_w_6502 = 1'b1;
    bus_if.ba_req   = 1'b0;
    bus_if.dma_req  = 1'b0;
    mreset();
    #1;
    chk_idle("rst_async");
    repeat (2) @(posedge clock);
    #1;
    chk_idle("rst_held");
    _reset = 1'b1;

    cyc(1, 0, 0);
    // DMA request while core reads: rdy low at +1, grant at +2.
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);

    // Video request while the core writes three times.
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);

    // Both together: video first, then DMA straight from VIC, then bursts.
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1);
    cyc(1, 0, 0);

    // Preempt a DMA burst with BA, then release both.
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 0, 0);

    // Abandoned request during drain.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);

    // Reset pulsed mid-VIC grant.
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    #2;
    _reset = 1'b0;
    #1;
    mreset();
    chk_idle("rst_mid_vic");
    @(posedge clock);
    #1;
    _reset = 1'b1;
    cyc(1, 0, 0);

    // Random traffic with sticky requests.
    ba_r = 1'b0; dma_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ba_r  = ba_r  ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      dma_r = dma_r ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      cyc(1'($urandom_range(0, 1)), ba_r, dma_r);
    end
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
- Decides which master owns the 8502-side address/data/R/W bus, cycle by cycle. Masters: the 6502 core (through the Fake8502 bridge), the video chip's BA request, and a DMA engine.
- Drives the bridge's aec input and the core's rdy input, and returns grants to the requesters.
- Enforces 6502 RDY semantics: the core only stalls on a read cycle, so up to MAX_WRITES back-to-back writes must be allowed to finish before the bus is handed over.

Parameters:
- MAX_WRITES, 3: maximum consecutive write cycles the core can issue after rdy falls; the bus is forced over once this count is reached.
- MAX_BURST, 0: maximum consecutive DMA-owned cycles before one forced CPU cycle; 0 = unlimited.
- BURST_W, 8: width of the DMA burst counter; must hold MAX_BURST.

Ports:
- clock, input, 1: system clock; all state updates on its rising edge.
- _reset, input, 1: asynchronous, active-low reset.
- r_w_6502, input, 1: core R/W for the current cycle (1 = read).
- ba_req, input, 1: video bus request, high priority, level-sensitive.
- dma_req, input, 1: DMA bus request, low priority, level-sensitive.
- aec, output, 1: 1 = core drives the bus through the bridge; 0 = bridge tri-stated.
- rdy, output, 1: core ready; 0 = core stalls on its next read.
- vic_grant, output, 1: video chip owns the bus this cycle.
- dma_grant, output, 1: DMA owns the bus this cycle.
- wait_cnt, output, 2: current consecutive-write count while draining; debug/status.

Behaviour:
- Reset (async, _reset=0): state=CPU, aec=1, rdy=1, vic_grant=0, dma_grant=0, wait_cnt=0, burst counter=0. Deassertion takes effect at the next rising clock.
- All outputs are registered, decoded from state. Exactly one of {aec, vic_grant, dma_grant} is 1 in every cycle.
- States: CPU, DRAIN, VIC, DMA, YIELD.
- CPU: aec=1, rdy=1. If ba_req or dma_req, go to DRAIN next cycle with rdy=0 and wait_cnt=0.
- DRAIN: aec=1, rdy=0. Each clock, sample r_w_6502:
  - If r_w_6502=1 (core halted on a read), or wait_cnt==MAX_WRITES, hand over next cycle: VIC if ba_req, else DMA if dma_req.
  - If r_w_6502=0 and wait_cnt<MAX_WRITES, increment wait_cnt and stay.
  - If both requests have dropped, return to CPU with rdy=1 (abandoned request).
- Handover latency: at most MAX_WRITES+2 clocks from request to grant. Exactly 2 clocks (request high → grant high) if the core is reading.
- VIC: aec=0, rdy=0, vic_grant=1, held while ba_req=1. When ba_req falls:
  - go to DMA if dma_req=1 (core is already halted, so no drain);
  - otherwise go to CPU with rdy=1 in the same cycle as aec=1.
- DMA: aec=0, rdy=0, dma_grant=1. Burst counter increments each DMA cycle. Exit rules, in priority order:
  - ba_req=1: go to VIC next cycle. DMA is preempted; dma_grant drops the same cycle vic_grant rises.
  - dma_req=0: go to CPU.
  - MAX_BURST≠0 and counter==MAX_BURST-1: go to YIELD.
- YIELD: aec=1, rdy=1 for exactly one cycle, burst counter cleared. Then:
  - go to DRAIN if any request is pending;
  - otherwise go to CPU.
- Simultaneous ba_req and dma_req in CPU or DRAIN: VIC wins.
- The burst counter clears on every entry to DMA from DRAIN or VIC. It saturates and never wraps.
- Reset asserted mid-grant: all grants drop asynchronously and aec=1 immediately.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding constants ST_CPU, ST_DRAIN, ST_VIC, ST_DMA, ST_YIELD (3-bit);
  - default MAX_WRITES value, shared with the bridge testbench.
- One natural sub-module, arb_write_drain: the wait_cnt counter plus the drain-complete compare. It outputs drain_done to the main FSM.

Test Plan:
- After reset, core idle: aec=1, rdy=1, no grants. Raise dma_req with r_w_6502=1 → rdy=0 at +1 clock, dma_grant=1 and aec=0 at +2.
- ba_req while core issues 3 writes (r_w_6502=0,0,0) → wait_cnt steps 0,1,2,3. vic_grant=1 on the cycle after wait_cnt==3, no earlier.
- dma_req and ba_req raised together → vic_grant first. Drop ba_req with dma_req held → dma_grant next cycle with aec still 0, and rdy never returns to 1 in between.
- MAX_BURST=4, dma_req held high → 4 dma_grant cycles, 1 YIELD cycle (aec=1, rdy=1), then DRAIN → DMA again. The pattern repeats.
- ba_req asserted during a DMA burst → dma_grant 1→0 and vic_grant 0→1 on the same edge. After ba_req drops with dma_req=0 → aec=1 and rdy=1.
- _reset pulsed low mid-VIC grant → vic_grant=0 and aec=1 immediately, without a clock edge. After release, state=CPU.
